// File: rtl/lut_key_table.sv
// lut_key_table: runtime-writable key/data table driving a packed MuxKey lut bus
module lut_key_table #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic                                   wr_del,
    input  logic [KEY_LEN-1:0]                     wr_key,
    input  logic [DATA_LEN-1:0]                    wr_data,
    input  logic                                   clr,
    output logic                                   resp_valid,
    output logic [1:0]                             resp_code,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
    output logic [NR_KEY-1:0]                      entry_valid,
    output logic [$clog2(NR_KEY+1)-1:0]            count,
    output logic                                   full
);
    localparam int PAIR = KEY_LEN + DATA_LEN;
    localparam int IW   = NR_KEY > 1 ? $clog2(NR_KEY) : 1;
    localparam int CW   = $clog2(NR_KEY+1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                           state;
    logic [IW-1:0]                    index;
    logic [NR_KEY-1:0][KEY_LEN-1:0]   keys;
    logic [NR_KEY-1:0][DATA_LEN-1:0]  datas;
    logic [NR_KEY-1:0]                valid;
    logic                             hit;
    logic                             has_free;
    logic [IW-1:0]                    hit_idx;
    logic [IW-1:0]                    free_idx;

    assign wr_ready    = (state == IDLE) && !clr;
    assign entry_valid = valid;
    assign full        = count == CW'(NR_KEY);

    genvar g;
    generate
        for (g = 0; g < NR_KEY; g++) begin : g_pair
            assign lut[PAIR*(g+1)-1 -: PAIR] = {keys[g], datas[g]};
        end
    endgenerate

    // Find the matching valid entry and the lowest-index free slot; count valid entries
    always_comb begin
        hit      = 1'b0;
        has_free = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        count    = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (valid[i] && keys[i] == wr_key) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
            count = count + CW'(valid[i]);
        end
    end

    // Request handling and the one-entry-per-cycle clear sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= '0;
            keys       <= '0;
            datas      <= '0;
            valid      <= '0;
            resp_valid <= 1'b0;
            resp_code  <= 2'b00;
        end else begin
            resp_valid <= 1'b0;
            if (state == CLEAR) begin
                valid[index] <= 1'b0;
                keys[index]  <= '0;
                datas[index] <= '0;
                index        <= index + IW'(1);
                if (index == IW'(NR_KEY - 1))
                    state <= IDLE;
            end else if (clr) begin
                state <= CLEAR;
                index <= '0;
            end else if (wr_valid) begin
                resp_valid <= 1'b1;
                if (wr_del && hit) begin
                    valid[hit_idx] <= 1'b0;
                    keys[hit_idx]  <= '0;
                    datas[hit_idx] <= '0;
                    resp_code      <= 2'b10;
                end else if (!wr_del && hit) begin
                    datas[hit_idx] <= wr_data;
                    resp_code      <= 2'b01;
                end else if (!wr_del && has_free) begin
                    valid[free_idx] <= 1'b1;
                    keys[free_idx]  <= wr_key;
                    datas[free_idx] <= wr_data;
                    resp_code       <= 2'b00;
                end else begin
                    resp_code <= 2'b11;
                end
            end
        end
    end
endmodule

// File: tb/tb_lut_key_table.sv
// tb_lut_key_table: directed-vector self-checking bench for lut_key_table
module tb_lut_key_table;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_del = 1'b0;
    logic [3:0]  wr_key = '0;
    logic [7:0]  wr_data = '0;
    logic        clr = 1'b0;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic [47:0] lut;
    logic [3:0]  entry_valid;
    logic [2:0]  count;
    logic        full;
    int          compared = 0;
    int          mismatched = 0;

    lut_key_table dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_del(wr_del), .wr_key(wr_key), .wr_data(wr_data), .clr(clr),
        .resp_valid(resp_valid), .resp_code(resp_code), .lut(lut),
        .entry_valid(entry_valid), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MuxKey behaviour: OR of data from every pair whose key matches
    function automatic logic [7:0] mux_out(input logic [47:0] l, input logic [3:0] k);
        logic [7:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            logic [11:0] p = l[12*i +: 12];
            if (p[11:8] == k) r |= p[7:0];
        end
        return r;
    endfunction

    task automatic req(input logic del, input logic [3:0] k, input logic [7:0] d, input logic [1:0] code);
        wr_valid = 1'b1;
        wr_del   = del;
        wr_key   = k;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check("resp_valid", 48'(resp_valid), 48'd1);
        check("resp_code", 48'(resp_code), 48'(code));
    endtask

    initial begin
        #2;
        check("rst_lut", lut, 48'd0);
        check("rst_valid", 48'(entry_valid), 48'd0);
        check("rst_count", 48'(count), 48'd0);
        check("rst_resp", 48'(resp_valid), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 48'(wr_ready), 48'd1);
        @(posedge clk);
        #1;
        // 1: first insert
        req(1'b0, 4'h3, 8'hA5, 2'b00);
        check("t1_lut", lut, 48'h3A5);
        check("t1_valid", 48'(entry_valid), 48'b0001);
        check("t1_count", 48'(count), 48'd1);
        check("t1_mux", 48'(mux_out(lut, 4'h3)), 48'hA5);
        @(posedge clk);
        #1;
        check("t1_pulse", 48'(resp_valid), 48'd0);
        // 2: update then back-to-back inserts
        req(1'b0, 4'h3, 8'h5A, 2'b01);
        check("t2_count_upd", 48'(count), 48'd1);
        req(1'b0, 4'h1, 8'h11, 2'b00);
        req(1'b0, 4'h2, 8'h22, 2'b00);
        req(1'b0, 4'h4, 8'h44, 2'b00);
        check("t2_lut", lut, 48'h444_222_111_35A);
        check("t2_full", 48'(full), 48'd1);
        check("t2_count", 48'(count), 48'd4);
        // 3: drop on full, delete, reuse slot
        req(1'b0, 4'h7, 8'h77, 2'b11);
        check("t3_lut_drop", lut, 48'h444_222_111_35A);
        req(1'b1, 4'h2, 8'hFF, 2'b10);
        check("t3_lut_del", lut, 48'h444_000_111_35A);
        check("t3_count", 48'(count), 48'd3);
        check("t3_full", 48'(full), 48'd0);
        req(1'b0, 4'h7, 8'h77, 2'b00);
        check("t3_lut_ins", lut, 48'h444_777_111_35A);
        check("t3_valid", 48'(entry_valid), 48'b1111);
        // 4: delete absent and present keys
        req(1'b1, 4'h9, 8'h00, 2'b11);
        check("t4_count", 48'(count), 48'd4);
        req(1'b1, 4'h3, 8'h00, 2'b10);
        check("t4_lut", lut, 48'h444_777_111_000);
        check("t4_valid", 48'(entry_valid), 48'b1110);
        // 5: clear wins over a simultaneous write
        req(1'b0, 4'h3, 8'hA5, 2'b00);
        check("t5_full", 48'(full), 48'd1);
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_del   = 1'b0;
        wr_key   = 4'h5;
        wr_data  = 8'h55;
        #1;
        check("t5_ready_clr", 48'(wr_ready), 48'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        wr_valid = 1'b0;
        check("t5_noresp", 48'(resp_valid), 48'd0);
        check("t5_count_start", 48'(count), 48'd4);
        for (int i = 0; i < 4; i++) begin
            clr = (i == 1);
            @(posedge clk);
            #1;
            clr = 1'b0;
            check("t5_count", 48'(count), 48'(3 - i));
            check("t5_ready", 48'(wr_ready), 48'(i == 3));
            check("t5_resp", 48'(resp_valid), 48'd0);
        end
        check("t5_lut", lut, 48'd0);
        // 6: reset mid-clear and with a pending response
        req(1'b0, 4'h1, 8'h11, 2'b00);
        req(1'b0, 4'h2, 8'h22, 2'b00);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("t6_mid_count", 48'(count), 48'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_lut", lut, 48'd0);
        check("t6_rst_valid", 48'(entry_valid), 48'd0);
        check("t6_rst_count", 48'(count), 48'd0);
        check("t6_rst_ready", 48'(wr_ready), 48'd1);
        rst_n = 1'b1;
        req(1'b0, 4'h6, 8'h66, 2'b00);
        rst_n = 1'b0;
        #1;
        check("t6_resp_drop", 48'(resp_valid), 48'd0);
        check("t6_code_rst", 48'(resp_code), 48'd0);
        rst_n = 1'b1;
        req(1'b0, 4'h0, 8'h00, 2'b00);
        check("t6_zero_valid", 48'(entry_valid), 48'b0001);
        check("t6_zero_count", 48'(count), 48'd1);
        check("t6_zero_lut", lut, 48'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
